// File: rtl/window_line_buffer.sv
// Sliding KxK window generator over a raster pixel stream.
// K-1 circular line buffers feed a KxK tap array; stride phase counters gate emits.
module window_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 26,
  parameter int IMG_HEIGHT = 26,
  parameter int K          = 2,
  parameter int STRIDE     = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            win_valid,
  output logic [K*K*DATA_WIDTH-1:0]       win_data,
  output logic [$clog2(IMG_HEIGHT)-1:0]   win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]    win_col,
  output logic                            frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_ARM  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ARM  = RW'(K - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] col_ph;
  logic [PW-1:0] row_ph;
  logic [CW-1:0] wc;
  logic [RW-1:0] wr;

  logic [DATA_WIDTH-1:0] lb       [K-1][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] taps     [K][K];
  logic [DATA_WIDTH-1:0] taps_nxt [K][K];
  logic [DATA_WIDTH-1:0] col_in   [K];
  logic [K*K*DATA_WIDTH-1:0] win_flat;

  logic accept;
  logic emit;
  logic last;

  assign accept = in_valid && !start;
  assign emit   = (col >= COL_ARM) && (row >= ROW_ARM) &&
                  (col_ph == '0) && (row_ph == '0);
  assign last   = (col == COL_LAST) && (row == ROW_LAST);

  // Row 0 of the column is the oldest line, row K-1 the live pixel.
  always_comb begin
    for (int r = 0; r < K - 1; r++) col_in[r] = lb[r][col];
    col_in[K-1] = in_data;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) taps_nxt[r][c] = taps[r][c+1];
      taps_nxt[r][K-1] = col_in[r];
    end
    win_flat = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_flat[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = taps_nxt[r][c];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < K - 2; i++) lb[i][col] <= lb[i+1][col];
      lb[K-2][col] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      col_ph     <= '0;
      row_ph     <= '0;
      wc         <= '0;
      wr         <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_data   <= '0;
      win_row    <= '0;
      win_col    <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) taps[r][c] <= '0;
    end else if (start) begin
      col        <= '0;
      row        <= '0;
      col_ph     <= '0;
      row_ph     <= '0;
      wc         <= '0;
      wr         <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (in_valid) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) taps[r][c] <= taps_nxt[r][c];
      win_valid  <= emit;
      frame_done <= last;
      if (emit) begin
        win_data <= win_flat;
        win_row  <= wr;
        win_col  <= wc;
      end
      if (col == COL_LAST) begin
        col    <= '0;
        col_ph <= '0;
        wc     <= '0;
        if (row == ROW_LAST) begin
          row    <= '0;
          row_ph <= '0;
          wr     <= '0;
        end else begin
          row <= row + RW'(1);
          if (row >= ROW_ARM) begin
            row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + PW'(1);
            if (row_ph == PH_LAST) wr <= wr + RW'(1);
          end
        end
      end else begin
        col <= col + CW'(1);
        if (col >= COL_ARM) begin
          col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + PW'(1);
          if (col_ph == PH_LAST) wc <= wc + CW'(1);
        end
      end
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule
